// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM encoding and the oversampling ratio
// that the baud generator, this transmitter and the future receiver agree on.
package uart_pkg;

  // Transmit sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } tx_state_t;

  // Baud generator ticks per serial bit (16x oversampling).
  localparam int NUM_TICKS = 16;

  // Larger of two integers, used to size counters at elaboration time.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer. Serialises one DBIT-wide byte LSB-first as
// start bit, data bits, then a stop period of SB_TICK oversampling ticks.
// All timing advances only on cycles where ticks=1.
//
// Handshake: while tx_busy=0 a cycle with tx_start=1 accepts din; the line
// drops to the start bit and tx_busy rises on the next edge. tx_start seen
// while tx_busy=1 is ignored. tx_done pulses for one cycle as tx_busy falls,
// and a tx_start in that same cycle is accepted, so frames can be chained
// with no idle gap.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int DBIT      = 8,
  parameter int SB_TICK   = 16,
  parameter int NUM_TICKS = uart_pkg::NUM_TICKS
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            ticks,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done
);

  // Tick counter covers the longer of a data bit and the stop period.
  localparam int SW = $clog2(max_int(NUM_TICKS, SB_TICK));
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_BIT_END  = SW'(NUM_TICKS - 1);
  localparam logic [SW-1:0] S_STOP_END = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST     = NW'(DBIT - 1);

  tx_state_t       state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // State, counters, shift register and registered line outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: counters only move on tick cycles.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_start) begin
          b_d     = din;
          s_d     = '0;
          n_d     = '0;
          state_d = START;
        end
      end
      START: begin
        if (ticks) begin
          if (s_q == S_BIT_END) begin
            s_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (ticks) begin
          if (s_q == S_BIT_END) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (ticks) begin
          if (s_q == S_STOP_END) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line and busy are computed from the next state so the register output
  // changes on the same edge as the state itself.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = b_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: reset, single frames, busy ignore,
// back-to-back frames, mid-frame reset, continuous and frozen ticks, and a
// second instance with a two-stop-bit period.
module tb_uart_tx_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       ticks;
  logic       tx_start, tx_start2;
  logic [7:0] din, din2;
  logic       tx, tx_busy, tx_done;
  logic       tx2, tx_busy2, tx_done2;

  int n_chk  = 0;
  int n_pass = 0;
  int sel    = 0;
  int tcnt   = 0;

  // Clock / reset block
  always #5 clock = ~clock;

  uart_tx_ctrl #(.DBIT(8), .SB_TICK(16), .NUM_TICKS(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .ticks    (ticks),
    .tx_start (tx_start),
    .din      (din),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  uart_tx_ctrl #(.DBIT(8), .SB_TICK(32), .NUM_TICKS(16)) dut32 (
    .clock    (clock),
    .reset    (reset),
    .ticks    (ticks),
    .tx_start (tx_start2),
    .din      (din2),
    .tx       (tx2),
    .tx_busy  (tx_busy2),
    .tx_done  (tx_done2)
  );

  // Outputs sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [2:0] obs3();
    return (sel != 0) ? {tx2, tx_busy2, tx_done2} : {tx, tx_busy, tx_done};
  endfunction

  // Expected {tx, busy, done} while inside bit window k (0=start, 9=stop).
  function automatic logic [2:0] exp_bits(input logic [7:0] d, input int k);
    if (k == 0)      return 3'b010;
    else if (k <= 8) return {d[k-1], 2'b10};
    else             return 3'b110;
  endfunction

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Hold idle for n cycles with ticks running; line must stay 1, not busy, no done.
  task automatic idle_check(input int n, input string tag);
    logic [2:0] o, wobs, wexp;
    bit bad;
    bad  = 0;
    wobs = 3'b100;
    wexp = 3'b100;
    for (int i = 0; i < n; i++) begin
      step();
      o = obs3();
      if (!bad && o !== 3'b100) begin
        bad  = 1;
        wobs = o;
      end
      ticks = ((i % 13) == 12);
    end
    chk(tag, {5'b0, wobs}, {5'b0, wexp});
  endtask

  // Launch one frame and check every cycle of it, one comparison per bit
  // window plus one at the tx_done cycle. per = clocks per tick, sb = stop
  // ticks, frz >= 0 freezes ticks for 100 clocks after cycle frz, ign > 0
  // pulses a competing tx_start at that cycle.
  task automatic run_frame(input logic [7:0] d, input int sb, input int per,
                           input int frz, input int ign, input string tag);
    int bitc, endc, cur, k, ce;
    logic [2:0] o, e, wobs, wexp;
    bit bad;
    bitc = 16 * per;
    endc = 9 * bitc + sb * per + ((frz >= 0) ? 100 : 0);
    if (sel != 0) begin
      tx_start2 = 1'b1;
      din2      = d;
    end else begin
      tx_start = 1'b1;
      din      = d;
    end
    tcnt  = 0;
    ticks = (per == 1);
    cur   = 0;
    bad   = 0;
    wobs  = 3'b010;
    wexp  = 3'b010;
    for (int c = 0; c <= endc; c++) begin
      step();
      if (c == 0) begin
        tx_start  = 1'b0;
        tx_start2 = 1'b0;
      end
      if (ign > 0 && c == ign) begin
        tx_start = 1'b1;
        din      = 8'h3C;
      end
      if (ign > 0 && c == ign + 1) tx_start = 1'b0;
      if (frz < 0 || c <= frz) ce = c;
      else if (c <= frz + 100) ce = frz;
      else ce = c - 100;
      o = obs3();
      if (c == endc) begin
        chk($sformatf("%s bit%0d", tag, cur), {5'b0, wobs}, {5'b0, wexp});
        chk($sformatf("%s done", tag), {5'b0, o}, 8'h05);
      end else begin
        k = ce / bitc;
        if (k > 9) k = 9;
        if (k != cur) begin
          chk($sformatf("%s bit%0d", tag, cur), {5'b0, wobs}, {5'b0, wexp});
          cur = k;
          bad = 0;
        end
        e = exp_bits(d, k);
        if (!bad) begin
          wobs = o;
          wexp = e;
          if (o !== e) bad = 1;
        end
      end
      if (frz >= 0 && c >= frz && c < frz + 100) begin
        ticks = 1'b0;
      end else begin
        tcnt++;
        ticks = (per == 1) || ((tcnt % per) == 0);
      end
    end
  endtask

  // Directed stimulus
  initial begin
    reset     = 1'b1;
    ticks     = 1'b0;
    tx_start  = 1'b1;
    din       = 8'hFF;
    tx_start2 = 1'b0;
    din2      = 8'h00;

    // Reset held 3 cycles with tx_start asserted.
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("reset cyc%0d", i), {5'b0, tx, tx_busy, tx_done}, 8'h04);
    end
    reset    = 1'b0;
    tx_start = 1'b0;
    step();
    chk("after reset", {5'b0, tx, tx_busy, tx_done}, 8'h04);
    idle_check(20, "idle after reset");

    // Single A5 frame at 13 clocks/tick with an ignored 3C request mid-frame.
    run_frame(8'hA5, 16, 13, -1, 500, "A5");
    idle_check(40, "no frame after A5");

    // Back-to-back: 0F requested in the tx_done cycle of C3.
    run_frame(8'hC3, 16, 13, -1, 0, "C3");
    run_frame(8'h0F, 16, 13, -1, 0, "0F chained");
    idle_check(40, "idle after 0F");

    // Reset during data bit 3 of an F0 frame.
    tx_start = 1'b1;
    din      = 8'hF0;
    tcnt     = 0;
    ticks    = 1'b0;
    for (int c = 0; c <= 900; c++) begin
      step();
      if (c == 0) tx_start = 1'b0;
      tcnt++;
      ticks = ((tcnt % 13) == 0);
    end
    chk("pre-reset bit3", {7'b0, tx}, 8'h00);
    reset = 1'b1;
    step();
    chk("mid-frame reset", {5'b0, tx, tx_busy, tx_done}, 8'h04);
    reset = 1'b0;
    idle_check(2300, "no done after abort");
    run_frame(8'h55, 16, 13, -1, 0, "55 after abort");
    idle_check(10, "idle after 55");

    // Ticks high every cycle: 160-clock frame.
    run_frame(8'h00, 16, 1, -1, 0, "00 fast");
    idle_check(10, "idle after fast");

    // Ticks frozen for 100 clocks in the middle of data bit 3.
    run_frame(8'h6B, 16, 13, 1000, 0, "6B freeze");
    idle_check(10, "idle after freeze");

    // Two stop bits on the second instance.
    sel = 1;
    run_frame(8'h81, 32, 13, -1, 0, "81 sb32");
    idle_check(10, "idle after sb32");
    sel = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
